// File: rtl/phi_setpoint_sequencer.sv
// Debounced up/down push-buttons -> saturated phase-angle target, slewed one degree
// per armed safe-update strobe. Define PHI_SEG_EN to add 7-segment target outputs.
module phi_setpoint_sequencer #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000,
    parameter int unsigned STEP            = 5,
    parameter int unsigned PHI_MIN         = 0,
    parameter int unsigned PHI_MAX         = 90,
    parameter int unsigned PHI_INIT        = 45,
    parameter int unsigned RAMP_DIV        = 1000
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_increase,
    input  logic        i_decrease,
    input  logic        i_sync,
    output logic [31:0] o_phi32,
    output logic [8:0]  o_target,
    output logic        o_update,
    output logic        o_busy,
    output logic        o_limit
`ifdef PHI_SEG_EN
    ,
    output logic [7:0]  o_seg0,
    output logic [7:0]  o_seg1,
    output logic [7:0]  o_seg2
`endif
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HR_W   = $clog2(HR_MAX + 1);
    localparam int unsigned TK_W   = $clog2(RAMP_DIV + 1);
    localparam logic LIMIT_INIT    = (PHI_INIT == PHI_MIN) || (PHI_INIT == PHI_MAX);

    typedef enum logic [1:0] {IDLE, STEP_FIRST, HOLD, REPEAT} state_t;

    // bit 0 = increase button, bit 1 = decrease button
    logic [1:0]      inc_sync_q, dec_sync_q;
    logic [1:0]      smp;
    logic [1:0]      deb_q, deb_prev_q;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [1:0]      press;
    logic            both_low;

    state_t          state_q, state_d;
    logic            dir_q, dir_d;
    logic [HR_W-1:0] hr_cnt_q, hr_cnt_d;
    logic            lock_q, lock_d;
    logic            do_step;
    logic            released;

    logic [8:0]      tgt_q, tgt_d;
    logic [9:0]      tgt_w, up_w, sel_w;

    logic [8:0]      phi_q;
    logic [TK_W-1:0] tick_q;
    logic            arm_q;
    logic            upd_q, busy_q, limit_q;

    assign smp      = {dec_sync_q[1], inc_sync_q[1]};
    assign press    = deb_prev_q & ~deb_q;
    assign both_low = (deb_q == 2'b00);
    assign released = dir_q ? deb_q[0] : deb_q[1];

    // Two-flop synchronizers plus per-button debounce counters
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            inc_sync_q  <= 2'b11;
            dec_sync_q  <= 2'b11;
            deb_q       <= 2'b11;
            deb_prev_q  <= 2'b11;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            inc_sync_q <= {inc_sync_q[0], i_increase};
            dec_sync_q <= {dec_sync_q[0], i_decrease};
            deb_prev_q <= deb_q;
            for (int b = 0; b < 2; b++) begin
                if (smp[b] == deb_q[b]) begin
                    db_cnt_q[b] <= '0;
                end else if (db_cnt_q[b] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_q[b]    <= smp[b];
                    db_cnt_q[b] <= '0;
                end else begin
                    db_cnt_q[b] <= db_cnt_q[b] + DB_W'(1);
                end
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q  <= IDLE;
            dir_q    <= 1'b0;
            hr_cnt_q <= '0;
            lock_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            hr_cnt_q <= hr_cnt_d;
            lock_q   <= lock_d;
        end
    end

    // Button FSM; both buttons low locks out service until both are released
    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        hr_cnt_d = hr_cnt_q;
        lock_d   = lock_q;
        do_step  = 1'b0;
        if (both_low) begin
            state_d  = IDLE;
            lock_d   = 1'b1;
            hr_cnt_d = '0;
        end else begin
            if (deb_q == 2'b11) begin
                lock_d = 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (!lock_q && (press != 2'b00)) begin
                        state_d = STEP_FIRST;
                        dir_d   = press[0];
                    end
                end
                STEP_FIRST: begin
                    do_step  = 1'b1;
                    hr_cnt_d = '0;
                    state_d  = HOLD;
                end
                HOLD: begin
                    if (released) begin
                        state_d = IDLE;
                    end else if (hr_cnt_q == HR_W'(REPEAT_DELAY - 1)) begin
                        state_d  = REPEAT;
                        hr_cnt_d = '0;
                    end else begin
                        hr_cnt_d = hr_cnt_q + HR_W'(1);
                    end
                end
                REPEAT: begin
                    if (released) begin
                        state_d = IDLE;
                    end else if (hr_cnt_q == HR_W'(REPEAT_PERIOD - 1)) begin
                        do_step  = 1'b1;
                        hr_cnt_d = '0;
                    end else begin
                        hr_cnt_d = hr_cnt_q + HR_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Saturating step arithmetic, one bit wider than the target so nothing wraps
    always_comb begin
        tgt_w = {1'b0, tgt_q};
        up_w  = tgt_w + 10'(STEP);
        if (dir_q) begin
            sel_w = (up_w > 10'(PHI_MAX)) ? 10'(PHI_MAX) : up_w;
        end else begin
            sel_w = (tgt_w < 10'(PHI_MIN + STEP)) ? 10'(PHI_MIN) : (tgt_w - 10'(STEP));
        end
        tgt_d = do_step ? 9'(sel_w) : tgt_q;
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            tgt_q <= 9'(PHI_INIT);
        end else begin
            tgt_q <= tgt_d;
        end
    end

    // Slew engine: arm after RAMP_DIV cycles, commit one degree on an armed sync
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            phi_q   <= 9'(PHI_INIT);
            tick_q  <= '0;
            arm_q   <= 1'b0;
            upd_q   <= 1'b0;
            busy_q  <= 1'b0;
            limit_q <= LIMIT_INIT;
        end else begin
            upd_q <= 1'b0;
            if (arm_q && i_sync && (phi_q != tgt_q)) begin
                phi_q  <= (phi_q < tgt_q) ? (phi_q + 9'd1) : (phi_q - 9'd1);
                upd_q  <= 1'b1;
                arm_q  <= 1'b0;
                tick_q <= '0;
            end else if (!arm_q) begin
                if (tick_q == TK_W'(RAMP_DIV - 1)) begin
                    arm_q  <= 1'b1;
                    tick_q <= '0;
                end else begin
                    tick_q <= tick_q + TK_W'(1);
                end
            end
            busy_q  <= (phi_q != tgt_q);
            limit_q <= (tgt_q == 9'(PHI_MIN)) || (tgt_q == 9'(PHI_MAX));
        end
    end

    assign o_phi32  = {23'd0, phi_q};
    assign o_target = tgt_q;
    assign o_update = upd_q;
    assign o_busy   = busy_q;
    assign o_limit  = limit_q;

`ifdef PHI_SEG_EN
    // Active-low segments, a on bit 0 through g on bit 6
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    logic [3:0] bcd0, bcd1, bcd2;

    always_comb begin
        bcd2 = 4'(tgt_q / 9'd100);
        bcd1 = 4'((tgt_q / 9'd10) % 9'd10);
        bcd0 = 4'(tgt_q % 9'd10);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_seg0 <= 8'hFF;
            o_seg1 <= 8'hFF;
            o_seg2 <= 8'hFF;
        end else begin
            o_seg0 <= {1'b1, seg7(bcd0)};
            o_seg1 <= {1'b1, seg7(bcd1)};
            o_seg2 <= {1'b1, seg7(bcd2)};
        end
    end
`endif

endmodule

// File: tb/tb_phi_setpoint_sequencer.sv
// Self-checking bench for phi_setpoint_sequencer: randomized button holds against a
// timing/saturation reference model, plus a cycle monitor for the slew engine.
module tb_phi_setpoint_sequencer;

    localparam int DEB   = 4;
    localparam int RD    = 20;
    localparam int RP    = 8;
    localparam int RDIV  = 2;
    localparam int STP   = 5;
    localparam int PMIN  = 0;
    localparam int PMAX  = 90;
    localparam int PINIT = 45;
    // raw edge -> first target change: 2 sync flops, DEB samples, press detect, step
    localparam int LAT   = 2 + DEB + 2;

    logic        clk = 1'b0;
    logic        i_reset, i_increase, i_decrease, i_sync;
    logic [31:0] o_phi32;
    logic [8:0]  o_target;
    logic        o_update, o_busy, o_limit;
`ifdef PHI_SEG_EN
    logic [7:0]  o_seg0, o_seg1, o_seg2;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_upd = 0;
    int last_upd = -100;
    int prev_phi = 0;
    int prev_tgt = 0;
    bit mon_en = 1'b0;
    bit sync_en = 1'b1;
    int sync_phase = 0;
    int model_tgt = PINIT;
    int chg_cyc[$];
    int chg_val[$];

    phi_setpoint_sequencer #(
        .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .STEP(STP),
        .PHI_MIN(PMIN), .PHI_MAX(PMAX), .PHI_INIT(PINIT), .RAMP_DIV(RDIV)
    ) dut (
        .i_clock(clk), .i_reset(i_reset), .i_increase(i_increase), .i_decrease(i_decrease),
        .i_sync(i_sync), .o_phi32(o_phi32), .o_target(o_target), .o_update(o_update),
        .o_busy(o_busy), .o_limit(o_limit)
`ifdef PHI_SEG_EN
        , .o_seg0(o_seg0), .o_seg1(o_seg1), .o_seg2(o_seg2)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int step_model(input int t, input bit up);
        if (up) return (t + STP > PMAX) ? PMAX : t + STP;
        return (t < PMIN + STP) ? PMIN : t - STP;
    endfunction

    // Advance n cycles; i_sync pulses every third cycle while enabled
    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            sync_phase = (sync_phase + 1) % 3;
            i_sync = sync_en && (sync_phase == 0);
        end
    endtask

    // Hold one button low for 'low' cycles and compare the target changes it produces
    task automatic hold_btn(input bit up, input int low);
        int c0, n_steps, t, nt, k;
        int ec[$];
        int ev[$];
        chg_cyc.delete();
        chg_val.delete();
        t = model_tgt;
        c0 = cyc;
        n_steps = 1 + ((low >= 2 + RD + RP) ? (low - 2 - RD) / RP : 0);
        for (int j = 0; j < n_steps; j++) begin
            nt = step_model(t, up);
            if (nt != t) begin
                ec.push_back(c0 + LAT + ((j == 0) ? 0 : RD + j * RP));
                ev.push_back(nt);
            end
            t = nt;
        end
        if (up) i_increase = 1'b0;
        else    i_decrease = 1'b0;
        cycles(low);
        i_increase = 1'b1;
        i_decrease = 1'b1;
        cycles(12);
        chk("step_count", chg_val.size(), ec.size());
        k = (chg_val.size() < ec.size()) ? chg_val.size() : ec.size();
        for (int j = 0; j < k; j++) begin
            chk("step_value", chg_val[j], ev[j]);
            chk("step_cycle", chg_cyc[j], ec[j]);
        end
        model_tgt = t;
        chk("target", int'(o_target), t);
    endtask

    task automatic wait_settle(input string tag);
        int n = 0;
        while ((o_phi32 != 32'(o_target)) && (n < 400)) begin
            cycles(1);
            n++;
        end
        chk(tag, int'(o_phi32 == 32'(o_target)), 1);
        cycles(2);
        chk("busy_idle", int'(o_busy), 0);
    endtask

    // Per-cycle monitor: slew steps, registered busy/limit lag, target change log
    always @(posedge clk) begin
        bit sb, rb;
        sb = i_sync;
        rb = i_reset;
        cyc++;
        #1;
        if (mon_en) begin
            if (rb) begin
                chk("rst_no_update", int'(o_update), 0);
            end else begin
                if (o_update) begin
                    chk("update_on_sync", int'(sb), 1);
                    chk("update_dir", int'(o_phi32), prev_phi + ((prev_tgt > prev_phi) ? 1 : -1));
                    chk("update_gap", int'((cyc - last_upd) >= RDIV), 1);
                    last_upd = cyc;
                    n_upd++;
                end else begin
                    chk("phi_hold", int'(o_phi32), prev_phi);
                end
                chk("busy_lag", int'(o_busy), int'(prev_phi != prev_tgt));
                chk("limit_lag", int'(o_limit), int'((prev_tgt == PMIN) || (prev_tgt == PMAX)));
            end
            if (int'(o_target) != prev_tgt) begin
                chg_cyc.push_back(cyc);
                chg_val.push_back(int'(o_target));
            end
        end
        prev_phi = int'(o_phi32);
        prev_tgt = int'(o_target);
    end

    initial begin
        int u0, t0, n;
        i_reset = 1'b1;
        i_increase = 1'b1;
        i_decrease = 1'b1;
        i_sync = 1'b0;

        // reset state
        cycles(2);
        chk("rst_phi", int'(o_phi32), PINIT);
        chk("rst_target", int'(o_target), PINIT);
        chk("rst_update", int'(o_update), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_limit", int'(o_limit), 0);
        i_reset = 1'b0;
        mon_en = 1'b1;

        // bounce shorter than the debounce window is ignored
        chg_cyc.delete();
        chg_val.delete();
        u0 = n_upd;
        for (int i = 0; i < 10; i++) begin
            i_increase = ~i_increase;
            cycles(2);
        end
        i_increase = 1'b1;
        cycles(12);
        chk("bounce_target", int'(o_target), PINIT);
        chk("bounce_changes", chg_val.size(), 0);
        chk("bounce_updates", n_upd - u0, 0);

        // single press, then a 5-degree ramp
        u0 = n_upd;
        hold_btn(1'b1, 10);
        wait_settle("ramp_50");
        chk("ramp_phi", int'(o_phi32), 50);
        chk("ramp_updates", n_upd - u0, 5);
        chk("phi_upper_zero", int'(o_phi32[31:9]), 0);

        // random single presses up to 80, then hold to saturate at 90
        while (model_tgt < 80) hold_btn(1'b1, int'($urandom_range(20, 6)));
        hold_btn(1'b1, 38 + int'($urandom_range(7, 0)));
        chk("sat_hi_target", int'(o_target), PMAX);
        chk("sat_hi_limit", int'(o_limit), 1);

        // back to 80, then hold decrease through 75, 70, 65
        hold_btn(1'b0, int'($urandom_range(20, 6)));
        hold_btn(1'b0, int'($urandom_range(20, 6)));
        hold_btn(1'b0, 38 + int'($urandom_range(7, 0)));
        chk("hold_dn_target", int'(o_target), 65);

        // long hold down to 10, then hold into the lower bound
        hold_btn(1'b0, 102 + int'($urandom_range(7, 0)));
        chk("to_10_target", int'(o_target), 10);
        hold_btn(1'b0, int'($urandom_range(80, 38)));
        chk("sat_lo_target", int'(o_target), PMIN);
        wait_settle("ramp_0");
        chk("sat_lo_limit", int'(o_limit), 1);

        // both pressed: no step, and no service until both released
        chg_cyc.delete();
        chg_val.delete();
        t0 = int'(o_target);
        i_increase = 1'b0;
        i_decrease = 1'b0;
        cycles(12);
        i_increase = 1'b1;
        cycles(30);
        i_decrease = 1'b1;
        cycles(12);
        chk("both_target", int'(o_target), t0);
        chk("both_changes", chg_val.size(), 0);
        hold_btn(1'b1, int'($urandom_range(20, 6)));

        // reset mid-ramp at phi 47, target 60
        i_reset = 1'b1;
        cycles(2);
        i_reset = 1'b0;
        model_tgt = PINIT;
        sync_en = 1'b0;
        for (int i = 0; i < 3; i++) hold_btn(1'b1, int'($urandom_range(20, 6)));
        chk("nosync_phi", int'(o_phi32), PINIT);
        chk("nosync_busy", int'(o_busy), 1);
        sync_en = 1'b1;
        n = 0;
        while ((o_phi32 != 32'd47) && (n < 100)) begin
            cycles(1);
            n++;
        end
        chk("reach_47", int'(o_phi32), 47);
        i_reset = 1'b1;
        cycles(1);
        chk("midramp_rst_phi", int'(o_phi32), PINIT);
        chk("midramp_rst_target", int'(o_target), PINIT);
        chk("midramp_rst_update", int'(o_update), 0);
        cycles(1);
        i_reset = 1'b0;
        cycles(4);
        chk("post_rst_busy", int'(o_busy), 0);
        chk("post_rst_phi", int'(o_phi32), PINIT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
